uart_rx_frame: RTL and testbench

Serial receive end of the system UART: recovers frames from the `RX_IN` line, which idles high (start 0, DATA_WIDTH data bits LSB-first, optional parity, stop 1). `CLK` is the UART receive clock, running at `PRESCALE` × baud. Each valid byte is presented on `P_DATA` with a one-cycle `data_valid` strobe to the system controller. Parity and stop-bit violations are reported and the byte is discarded.

---
 rtl/uart_rx_frame.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// UART receive framer: start / DATA_WIDTH data bits LSB-first / optional parity / stop.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by 3-sample majority around mid-bit.
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BCW = $clog2(DATA_WIDTH + 4);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_reg, state_next;
    logic [5:0]              edge_cnt_reg, edge_cnt_next;
    logic [BCW-1:0]          bit_cnt_reg, bit_cnt_next;

    logic [5:0]              p_reg;
    logic                    par_en_reg;
    logic                    par_typ_reg;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   shift_next;
    logic                    par_bit_reg;
    logic                    stop_bit_reg;
    logic [DATA_WIDTH-1:0]   p_data_reg;
    logic                    data_valid_reg;
    logic                    par_err_reg;
    logic                    stp_err_reg;

    logic [5:0]              half;
    logic                    wrap;
    logic                    sample_now;
    logic                    bit_val;
    logic                    latch_cfg;
    logic                    shift_en;
    logic                    par_cap;
    logic                    stop_cap;
    logic                    frame_done;
    logic                    parity_bad;
    logic [5:0]              prescale_legal;

    assign half = {1'b0, p_reg[5:1]};
    assign wrap = (edge_cnt_reg == (p_reg - 6'd1));

    assign prescale_legal = ((PRESCALE == 6'd8) || (PRESCALE == 6'd16) || (PRESCALE == 6'd32))
                          ? PRESCALE : 6'd8;

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Samples at P/2-1 and P/2 are held; the third comes straight from the line at P/2+1.
    logic [1:0] early_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            early_reg <= 2'b00;
        end else begin
            if (edge_cnt_reg == (half - 6'd1))
                early_reg[0] <= RX_IN;
            if (edge_cnt_reg == half)
                early_reg[1] <= RX_IN;
        end
    end

    assign sample_now = (state_reg != IDLE) && (edge_cnt_reg == (half + 6'd1));
    assign bit_val    = (early_reg[0] & early_reg[1]) |
                        (early_reg[0] & RX_IN) |
                        (early_reg[1] & RX_IN);
`else
    assign sample_now = (state_reg != IDLE) && (edge_cnt_reg == half);
    assign bit_val    = RX_IN;
`endif

    // Right shift so the first data bit received lands in bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_shift
            assign shift_next[gi] = shift_reg[gi+1];
        end
    endgenerate
    assign shift_next[DATA_WIDTH-1] = bit_val;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            edge_cnt_reg <= 6'd0;
            bit_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            edge_cnt_reg <= edge_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        edge_cnt_next = edge_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        latch_cfg     = 1'b0;
        shift_en      = 1'b0;
        par_cap       = 1'b0;
        stop_cap      = 1'b0;
        frame_done    = 1'b0;

        if (state_reg == IDLE) begin
            edge_cnt_next = 6'd0;
            bit_cnt_next  = '0;
            if (!RX_IN) begin
                // This edge is edge 0 of the start bit, so counting resumes at 1.
                state_next    = START;
                edge_cnt_next = 6'd1;
                latch_cfg     = 1'b1;
            end
        end else begin
            edge_cnt_next = wrap ? 6'd0 : edge_cnt_reg + 6'd1;
            if (wrap)
                bit_cnt_next = bit_cnt_reg + 1'b1;

            case (state_reg)
                START: begin
                    if (sample_now && bit_val) begin
                        state_next    = IDLE;
                        edge_cnt_next = 6'd0;
                        bit_cnt_next  = '0;
                    end else if (wrap) begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    shift_en = sample_now;
                    if (wrap && (bit_cnt_reg == BCW'(DATA_WIDTH)))
                        state_next = par_en_reg ? PARITY : STOP;
                end
                PARITY: begin
                    par_cap = sample_now;
                    if (wrap)
                        state_next = STOP;
                end
                STOP: begin
                    stop_cap = sample_now;
                    if (wrap) begin
                        state_next    = IDLE;
                        edge_cnt_next = 6'd0;
                        bit_cnt_next  = '0;
                        frame_done    = 1'b1;
                    end
                end
                default: begin
                    state_next    = IDLE;
                    edge_cnt_next = 6'd0;
                    bit_cnt_next  = '0;
                end
            endcase
        end
    end

    assign parity_bad = par_en_reg && (((^shift_reg) ^ par_typ_reg) != par_bit_reg);

    always_ff @(posedge CLK) begin
        if (RST) begin
            p_reg          <= 6'd8;
            par_en_reg     <= 1'b0;
            par_typ_reg    <= 1'b0;
            shift_reg      <= '0;
            par_bit_reg    <= 1'b0;
            stop_bit_reg   <= 1'b1;
            p_data_reg     <= '0;
            data_valid_reg <= 1'b0;
            par_err_reg    <= 1'b0;
            stp_err_reg    <= 1'b0;
        end else begin
            data_valid_reg <= 1'b0;
            par_err_reg    <= 1'b0;
            stp_err_reg    <= 1'b0;

            if (latch_cfg) begin
                p_reg       <= prescale_legal;
                par_en_reg  <= PAR_EN;
                par_typ_reg <= PAR_TYP;
            end
            if (shift_en)
                shift_reg <= shift_next;
            if (par_cap)
                par_bit_reg <= bit_val;
            if (stop_cap)
                stop_bit_reg <= bit_val;

            if (frame_done) begin
                par_err_reg <= parity_bad;
                stp_err_reg <= !stop_bit_reg;
                if (!parity_bad && stop_bit_reg) begin
                    data_valid_reg <= 1'b1;
                    p_data_reg     <= shift_reg;
                end
            end
        end
    end

    assign P_DATA     = p_data_reg;
    assign data_valid = data_valid_reg;
    assign par_err    = par_err_reg;
    assign stp_err    = stp_err_reg;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: one task per scenario with inline checks.
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd16;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0;
    int pe_cnt = 0;
    int se_cnt = 0;

    always #5 clk = ~clk;

    uart_rx_frame #(.DATA_WIDTH(8)) dut (
        .CLK        (clk),
        .RST        (rst),
        .RX_IN      (rx_in),
        .PRESCALE   (prescale),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .P_DATA     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid) dv_cnt++;
            if (par_err)    pe_cnt++;
            if (stp_err)    se_cnt++;
        end
    end

    // Drives one frame edge by edge; returns #1 after edge F*P-1, or early after max_edges edges.
    // Config inputs are scrambled after edge 0 to show they are latched at frame start.
    task automatic send_frame(input logic [7:0] data, input int p, input logic [5:0] p_port,
                              input logic pen, input logic ptyp, input logic pbit,
                              input logic sbit, input logic inv_mid, input int max_edges);
        logic bitv [0:10];
        int   nbits;
        int   n;
        bitv[0] = 1'b0;
        for (int i = 0; i < 8; i++) bitv[i+1] = data[i];
        if (pen) begin
            bitv[9] = pbit; bitv[10] = sbit; nbits = 11;
        end else begin
            bitv[9] = sbit; bitv[10] = 1'b1; nbits = 10;
        end
        n = 0;
        for (int b = 0; b < nbits; b++) begin
            for (int e = 0; e < p; e++) begin
                if (max_edges > 0 && n == max_edges) return;
                @(negedge clk);
                if (n == 0) begin
                    prescale = p_port; par_en = pen; par_typ = ptyp;
                end else if (n == 1) begin
                    prescale = (p_port == 6'd16) ? 6'd32 : 6'd16;
                    par_en = ~pen; par_typ = ~ptyp;
                end
                rx_in = bitv[b] ^ (inv_mid && b >= 1 && b <= 8 && e == p / 2);
                n++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL reset_p_data: got %h want 00", p_data); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b want 0", par_err); end
        checks++; if (stp_err !== 1'b0) begin errors++; $display("FAIL reset_stp_err: got %b want 0", stp_err); end
        $display("reset: P_DATA=%h data_valid=%b par_err=%b stp_err=%b", p_data, data_valid, par_err, stp_err);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8n1();
        int dv0;
        dv0 = dv_cnt;
        send_frame(8'hA5, 8, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL a5_early: strobes seen %0d want 0", dv_cnt - dv0); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL a5_valid: got %b want 1", data_valid); end
        checks++; if (p_data !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h want a5", p_data); end
        checks++; if (par_err !== 1'b0 || stp_err !== 1'b0) begin errors++; $display("FAIL a5_errs: par=%b stp=%b want 0 0", par_err, stp_err); end
        $display("8N1 P=8 0xA5: data_valid=%b P_DATA=%h par_err=%b stp_err=%b", data_valid, p_data, par_err, stp_err);
        @(posedge clk); #1;
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL a5_one_cycle: got %b want 0", data_valid); end
    endtask

    task automatic test_parity_error();
        int pe0;
        int dv0;
        pe0 = pe_cnt; dv0 = dv_cnt;
        send_frame(8'h3C, 16, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        checks++; if (pe_cnt !== pe0) begin errors++; $display("FAIL 3c_early: strobes seen %0d want 0", pe_cnt - pe0); end
        checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL 3c_par_err: got %b want 1", par_err); end
        checks++; if (data_valid !== 1'b0 || stp_err !== 1'b0) begin errors++; $display("FAIL 3c_other: valid=%b stp=%b want 0 0", data_valid, stp_err); end
        checks++; if (p_data !== 8'hA5) begin errors++; $display("FAIL 3c_hold: got %h want a5", p_data); end
        $display("8E1 P=16 0x3C bad parity: par_err=%b data_valid=%b P_DATA=%h", par_err, data_valid, p_data);
        @(posedge clk); #1;
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL 3c_one_cycle: got %b want 0", par_err); end
        checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL 3c_no_valid: strobes %0d want 0", dv_cnt - dv0); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h00, 32, 6'd32, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        checks++; if (stp_err !== 1'b1) begin errors++; $display("FAIL 00_stp_err: got %b want 1", stp_err); end
        checks++; if (par_err !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL 00_other: par=%b valid=%b want 0 0", par_err, data_valid); end
        $display("8O1 P=32 0x00 stop=0: stp_err=%b par_err=%b data_valid=%b", stp_err, par_err, data_valid);
        send_frame(8'h81, 32, 6'd32, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL 81_valid: got %b want 1", data_valid); end
        checks++; if (p_data !== 8'h81) begin errors++; $display("FAIL 81_data: got %h want 81", p_data); end
        checks++; if (par_err !== 1'b0 || stp_err !== 1'b0) begin errors++; $display("FAIL 81_errs: par=%b stp=%b want 0 0", par_err, stp_err); end
        $display("8O1 P=32 0x81 back-to-back: data_valid=%b P_DATA=%h", data_valid, p_data);
        @(negedge clk);
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_glitch();
        int dv0;
        int pe0;
        int se0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        @(negedge clk);
        prescale = 6'd16; par_en = 1'b0;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (dv_cnt !== dv0 || pe_cnt !== pe0 || se_cnt !== se0) begin
            errors++; $display("FAIL glitch_strobe: dv=%0d pe=%0d se=%0d want 0 0 0", dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0);
        end
        $display("glitch 3 cycles P=16: strobes dv=%0d pe=%0d se=%0d", dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0);
        send_frame(8'h5A, 16, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL 5a_valid: got %b want 1", data_valid); end
        checks++; if (p_data !== 8'h5A) begin errors++; $display("FAIL 5a_data: got %h want 5a", p_data); end
        $display("8N1 P=16 0x5A after glitch: data_valid=%b P_DATA=%h", data_valid, p_data);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int dv0;
        dv0 = dv_cnt;
        send_frame(8'hC3, 16, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 88);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (p_data !== 8'h00 || data_valid !== 1'b0 || par_err !== 1'b0 || stp_err !== 1'b0) begin
            errors++; $display("FAIL midreset_outs: P_DATA=%h valid=%b par=%b stp=%b want 00 0 0 0", p_data, data_valid, par_err, stp_err);
        end
        @(negedge clk);
        rst = 1'b0;
        rx_in = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL midreset_drop: strobes %0d want 0", dv_cnt - dv0); end
        $display("reset at data bit 4: P_DATA=%h strobes=%0d", p_data, dv_cnt - dv0);
        // PRESCALE=12 is illegal and must run as P=8.
        send_frame(8'hF0, 8, 6'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL f0_valid: got %b want 1", data_valid); end
        checks++; if (p_data !== 8'hF0) begin errors++; $display("FAIL f0_data: got %h want f0", p_data); end
        $display("8N1 P=12->8 0xF0 after reset: data_valid=%b P_DATA=%h", data_valid, p_data);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mid_sample_noise();
        logic [7:0] want;
`ifdef UART_RX_MAJORITY_VOTE_EN
        want = 8'h96;
`else
        want = 8'h69;
`endif
        send_frame(8'h96, 16, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL noise_valid: got %b want 1", data_valid); end
        checks++; if (p_data !== want) begin errors++; $display("FAIL noise_data: got %h want %h", p_data, want); end
        checks++; if (par_err !== 1'b0 || stp_err !== 1'b0) begin errors++; $display("FAIL noise_errs: par=%b stp=%b want 0 0", par_err, stp_err); end
        $display("8E1 P=16 0x96 mid-bit inverted: data_valid=%b P_DATA=%h par_err=%b", data_valid, p_data, par_err);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity_error();
        test_back_to_back();
        test_glitch();
        test_reset_mid_frame();
        test_mid_sample_noise();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
